// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// the registered status bundle derived from each state.
package mem_loader_pkg;

    localparam int MEM_WORDS = 1024;
    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    typedef struct packed {
        logic byte_ready;
        logic busy;
        logic done;
        logic error;
        logic cpu_reset_n;
    } status_t;

    // Status flags are loaded together with the state they belong to, so they stay registered.
    function automatic status_t status_of(state_t s);
        status_t r;
        r             = '0;
        r.byte_ready  = (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CSUM);
        r.busy        = (s == HDR0) || (s == HDR1) || (s == DATA) || (s == WRITE);
        r.done        = (s == DONE);
        r.error       = (s == ERR);
        r.cpu_reset_n = (s == DONE);
        return r;
    endfunction

endpackage

// File: rtl/mem_program_loader_if.sv
// Byte-stream input and word-memory write port of the program loader.
// master = loader side, slave = byte source / memory side.
interface mem_program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_ren, mem_wen, mem_addr, mem_din
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_program_loader_byte_word_assembler.sv
// Purpose: packs four little-endian bytes into a 32-bit word.
// Latency: word/word_full are combinational with the 4th byte, so the caller can register them.
// Backpressure: none; shifts only when shift_en is high.
module byte_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);
    logic [31:0] shift_q;
    logic [1:0]  byte_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            shift_q  <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            shift_q  <= {byte_in, shift_q[31:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Newest byte enters at the top, so after four shifts the first byte sits in [7:0].
    assign word      = {byte_in, shift_q[31:8]};
    assign word_full = shift_en && (byte_idx == 2'd3);

endmodule

// File: rtl/mem_program_loader.sv
// Purpose: loads a length-prefixed byte image into word memory, holding the CPU in reset until done (LOADER_CHECKSUM_EN adds a trailing XOR byte).
// Latency: mem_wen the cycle after a word's 4th byte; cpu_reset_n rises the cycle after the last write.
// Backpressure: byte_ready drops during the WRITE cycle and outside a load; unaccepted bytes must be held.
module mem_program_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = MEM_WORDS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    mem_program_loader_if.master bus,
    output logic                 cpu_reset_n,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t LAST_ST = CSUM;
`else
    localparam state_t LAST_ST = DONE;
`endif

    state_t      state;
    status_t     sts;
    logic [7:0]  n_lo;
    logic [15:0] n_words;
    logic [15:0] word_cnt;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic              transfer;
    logic              start_ok;
    logic [15:0]       hdr_n;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       asm_word;
    logic              asm_full;

    assign transfer = bus.byte_valid && sts.byte_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign hdr_n    = {bus.byte_data, n_lo};
    assign wr_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt);

    byte_word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_ok),
        .shift_en  ((state == DATA) && transfer),
        .byte_in   (bus.byte_data),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sts      <= '0;
            n_lo     <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            wen_q <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR0;
                        sts      <= status_of(HDR0);
                        n_words  <= '0;
                        word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q   <= '0;
`endif
                    end
                end
                HDR0: begin
                    if (transfer) begin
                        n_lo  <= bus.byte_data;
                        state <= HDR1;
                        sts   <= status_of(HDR1);
                    end
                end
                HDR1: begin
                    if (transfer) begin
                        n_words <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            state <= LAST_ST;
                            sts   <= status_of(LAST_ST);
                        end else if (int'(hdr_n) > MAX_WORDS) begin
                            state <= ERR;
                            sts   <= status_of(ERR);
                        end else begin
                            state  <= DATA;
                            sts    <= status_of(DATA);
                            addr_q <= 32'(ADDR_W'(BASE_ADDR));
                        end
                    end
                end
                DATA: begin
                    if (transfer) begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.byte_data;
`endif
                        if (asm_full) begin
                            state  <= WRITE;
                            sts    <= status_of(WRITE);
                            wen_q  <= 1'b1;
                            din_q  <= asm_word;
                            addr_q <= 32'(wr_addr);
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 16'd1;
                    if (word_cnt + 16'd1 == n_words) begin
                        state <= LAST_ST;
                        sts   <= status_of(LAST_ST);
                    end else begin
                        state <= DATA;
                        sts   <= status_of(DATA);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (transfer) begin
                        if (bus.byte_data == csum_q) begin
                            state <= DONE;
                            sts   <= status_of(DONE);
                        end else begin
                            state <= ERR;
                            sts   <= status_of(ERR);
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    sts   <= status_of(IDLE);
                end
            endcase
        end
    end

    assign bus.byte_ready = sts.byte_ready;
    assign bus.mem_ren    = 1'b0;
    assign bus.mem_wen    = wen_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_din    = din_q;
    assign cpu_reset_n    = sts.cpu_reset_n;
    assign busy           = sts.busy;
    assign done           = sts.done;
    assign error          = sts.error;

endmodule

// File: tb/tb_mem_program_loader.sv
// Randomised scoreboard bench for mem_program_loader: expected memory writes are
// queued from a byte-level image model and popped by a write monitor.
module tb_mem_program_loader;

    localparam int TB_ADDR_W = 10;
    localparam int TB_BASE   = 0;
    localparam int TB_MAX    = 1024;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset_n, busy, done, error;

    mem_program_loader_if bus ();

    mem_program_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] data_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    bit         csum_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_wen pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && bus.mem_wen) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr 0x%0h din 0x%0h with empty scoreboard",
                         bus.mem_addr, bus.mem_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", bus.mem_addr, e.addr);
                check("write_din", bus.mem_din, e.din);
                check("write_ren", bus.mem_ren, 0);
                check("write_ready_low", bus.byte_ready, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int nbytes);
        data_q.delete();
        for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: word i = little-endian bytes 4i..4i+3, written at (BASE + i) mod 2^ADDR_W.
    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.din  = 32'(data_q[4*i]) + (32'(data_q[4*i+1]) << 8)
                   + (32'(data_q[4*i+2]) << 16) + (32'(data_q[4*i+3]) << 24);
            e.addr = 32'((TB_BASE + i) % (1 << TB_ADDR_W));
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke);
        int waited;
        if (gaps) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        start          = poke;
        waited         = 0;
        forever begin
            @(negedge clock);
            if (bus.byte_ready) break;
            waited++;
            if (waited > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_accept_timeout: byte 0x%0h not accepted in 50 cycles", b);
                break;
            end
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {bus.byte_ready, bus.mem_wen, bus.mem_ren, cpu_reset_n, busy, done, error}, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_din"}, bus.mem_din, 0);
    endtask

    task automatic check_end(input bit exp_done, input bit exp_err, input int delay);
        @(negedge clock);
        if (delay == 2) begin
            check("last_write_latency", bus.mem_wen, 1);
            check("cpu_held_during_write", cpu_reset_n, 0);
            @(negedge clock);
        end
        check("end_done", done, exp_done);
        check("end_error", error, exp_err);
        check("end_cpu_reset_n", cpu_reset_n, exp_done);
        check("end_busy", busy, 0);
        check("end_ready", bus.byte_ready, 0);
        check("sb_drained", exp_q.size(), 0);
    endtask

    // One complete load of N words from data_q; bad flips the checksum byte.
    task automatic run_load(input int n, input bit bad, input bit gaps);
        logic [7:0]  x;
        logic [15:0] hdr;
        bit          legal;
        x     = 8'h00;
        hdr   = 16'(n);
        legal = (n <= TB_MAX);
        if (legal) begin
            push_words(n);
            for (int i = 0; i < 4 * n; i++) x = x ^ data_q[i];
        end
        do_start();
        send_byte(hdr[7:0], gaps, 1'b0);
        send_byte(hdr[15:8], gaps, 1'b0);
        if (legal) begin
            for (int i = 0; i < 4 * n; i++) send_byte(data_q[i], gaps, gaps && (i == 2));
            if (csum_en) send_byte(bad ? (x ^ 8'h01) : x, gaps, 1'b0);
        end
        bus.byte_valid = 1'b0;
        if (!legal)           check_end(1'b0, 1'b1, 1);
        else if (csum_en)     check_end(!bad, bad, 1);
        else                  check_end(1'b1, 1'b0, (n > 0) ? 2 : 1);
    endtask

    initial begin
`ifdef LOADER_CHECKSUM_EN
        csum_en = 1'b1;
`else
        csum_en = 1'b0;
`endif
        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(posedge clock); #1;

        // Two-word image with valid held through the WRITE cycles.
        data_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, 1'b0, 1'b0);

        // Empty image.
        data_q.delete();
        run_load(0, 1'b0, 1'b1);

        // Oversize header (1025), then recovery with a legal one-word image.
        run_load(1025, 1'b0, 1'b1);
        fill_random(4);
        run_load(1, 1'b0, 1'b1);

        // Reset after 5 data bytes: only word 0 may have been written.
        fill_random(8);
        push_words(1);
        do_start();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(data_q[i], 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midload_reset");
        check("midload_sb", exp_q.size(), 0);
        bus.byte_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        fill_random(4);
        run_load(1, 1'b0, 1'b0);

        if (csum_en) begin
            data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
            run_load(1, 1'b0, 1'b0);
            run_load(1, 1'b1, 1'b0);
        end

        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(0, 6);
            if ($urandom_range(0, 9) == 0) n = TB_MAX + $urandom_range(1, 3000);
            fill_random(4 * n);
            run_load(n, csum_en && ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
